// File: rtl/fft_arb_if.sv
// Requester/FFT-side bundle for fft_arb.
// slave is the arbiter view, master the driving environment.
interface fft_arb_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 9
);
   localparam int IW = $clog2(DEPTH + 1);

   logic                 en;
   logic                 req0;
   logic                 req1;
   logic signed [DW-1:0] din0_re [16];
   logic signed [DW-1:0] din0_im [16];
   logic signed [DW-1:0] din1_re [16];
   logic signed [DW-1:0] din1_im [16];
   logic                 gnt0;
   logic                 gnt1;
   logic                 fft_valid;
   logic signed [DW-1:0] fft_din_re [16];
   logic signed [DW-1:0] fft_din_im [16];
   logic                 fft_output_en;
   logic                 done0;
   logic                 done1;
   logic [IW-1:0]        inflight;
   logic                 err_spurious;

   modport slave (
      input  en, req0, req1,
      input  din0_re, din0_im, din1_re, din1_im,
      input  fft_output_en,
      output gnt0, gnt1, fft_valid,
      output fft_din_re, fft_din_im,
      output done0, done1, inflight, err_spurious
   );

   modport master (
      output en, req0, req1,
      output din0_re, din0_im, din1_re, din1_im,
      output fft_output_en,
      input  gnt0, gnt1, fft_valid,
      input  fft_din_re, fft_din_im,
      input  done0, done1, inflight, err_spurious
   );
endinterface

// File: rtl/fft_arb.sv
// Two-requester round-robin launcher for fft_top with an
// in-order tag FIFO that routes completions back to owners.
module fft_arb #(
   parameter int DEPTH = 4,
   parameter int DW    = 9
) (
   input  logic    clk,
   input  logic    rstn,
   fft_arb_if.slave io
);
   localparam int IW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] FULL = IW'(DEPTH);

   logic [IW-1:0]        cnt;
   logic [PW-1:0]        wp;
   logic [PW-1:0]        rp;
   logic [DEPTH-1:0]     tags;
   logic                 last;
   logic                 err;
   logic                 vld;
   logic signed [DW-1:0] dre [16];
   logic signed [DW-1:0] dim [16];

   logic ready;
   logic g0;
   logic g1;
   logic push;
   logic pop;
   logic head;

   // slot freed by a same-cycle completion is not reusable until next edge
   always_comb begin
      ready = rstn & io.en & (cnt < FULL);
      g0    = ready & io.req0 & (~io.req1 | last);
      g1    = ready & io.req1 & (~io.req0 | ~last);
      push  = g0 | g1;
      pop   = rstn & io.fft_output_en & (cnt != '0);
      head  = tags[rp];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= '0;
         wp   <= '0;
         rp   <= '0;
         tags <= '0;
         last <= 1'b1;
         err  <= 1'b0;
         vld  <= 1'b0;
         for (int k = 0; k < 16; k++) begin
            dre[k] <= '0;
            dim[k] <= '0;
         end
      end else begin
         vld <= push;
         if (push) begin
            last     <= g1;
            tags[wp] <= g1;
            wp       <= wp + 1'b1;
            for (int k = 0; k < 16; k++) begin
               dre[k] <= g1 ? io.din1_re[k] : io.din0_re[k];
               dim[k] <= g1 ? io.din1_im[k] : io.din0_im[k];
            end
         end
         if (pop) rp <= rp + 1'b1;
         if (push && !pop) cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
         if (io.fft_output_en && cnt == '0) err <= 1'b1;
      end
   end

   assign io.gnt0         = g0;
   assign io.gnt1         = g1;
   assign io.fft_valid    = vld;
   assign io.fft_din_re   = dre;
   assign io.fft_din_im   = dim;
   assign io.done0        = pop & ~head;
   assign io.done1        = pop & head;
   assign io.inflight     = cnt;
   assign io.err_spurious = err;
endmodule

// File: tb/tb_fft_arb.sv
// Directed bench for fft_arb: stimulus queues expected frames
// and completion tags, a negedge monitor pops and compares.
module tb_fft_arb;
   localparam int DEPTH = 4;
   localparam int DW    = 9;

   logic clk = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   fft_arb_if #(.DEPTH(DEPTH), .DW(DW)) io ();

   fft_arb #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (io)
   );

   int checks = 0;
   int failures = 0;
   int exp_frame [$];
   int exp_tag [$];
   int ms;
   int mok;

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic set_frame(int r, int seed);
      for (int k = 0; k < 16; k++) begin
         if (r == 0) begin
            io.din0_re[k] = DW'(k + seed);
            io.din0_im[k] = DW'(-(k + seed));
         end else begin
            io.din1_re[k] = DW'(k + seed);
            io.din1_im[k] = DW'(-(k + seed));
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      exp_frame.delete();
      exp_tag.delete();
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (io.fft_valid) begin
            if (exp_frame.size() == 0) begin
               check("valid_unexp", 1, 0);
            end else begin
               ms = exp_frame.pop_front();
               mok = 1;
               for (int k = 0; k < 16; k++) begin
                  if (io.fft_din_re[k] != k + ms) mok = 0;
                  if (io.fft_din_im[k] != -(k + ms)) mok = 0;
               end
               check("frame_re0", io.fft_din_re[0], ms);
               check("frame_lanes", mok, 1);
            end
         end
         if (io.done0 || io.done1) begin
            check("done_onehot", io.done0 & io.done1, 0);
            if (exp_tag.size() == 0) check("done_unexp", 1, 0);
            else check("done_tag", io.done1, exp_tag.pop_front());
         end
      end
   end

   initial begin
      io.en = 1'b1;
      io.req0 = 1'b0;
      io.req1 = 1'b0;
      io.fft_output_en = 1'b0;
      set_frame(0, 0);
      set_frame(1, 0);
      #12;
      io.req0 = 1'b1;
      io.req1 = 1'b1;
      io.fft_output_en = 1'b1;
      #1;
      check("rst_gnt0", io.gnt0, 0);
      check("rst_gnt1", io.gnt1, 0);
      check("rst_done0", io.done0, 0);
      check("rst_done1", io.done1, 0);
      check("rst_valid", io.fft_valid, 0);
      check("rst_inflight", io.inflight, 0);
      check("rst_err", io.err_spurious, 0);
      check("rst_din", io.fft_din_re[3], 0);
      io.req0 = 1'b0;
      io.req1 = 1'b0;
      io.fft_output_en = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // single requester
      set_frame(0, 0);
      io.req0 = 1'b1;
      #1;
      check("t1_gnt0", io.gnt0, 1);
      check("t1_gnt1", io.gnt1, 0);
      exp_frame.push_back(0);
      exp_tag.push_back(0);
      cyc();
      io.req0 = 1'b0;
      check("t1_infl1", io.inflight, 1);
      cyc();
      check("t1_valid_drop", io.fft_valid, 0);
      check("t1_din_hold", io.fft_din_re[1], 1);
      io.fft_output_en = 1'b1;
      cyc();
      io.fft_output_en = 1'b0;
      check("t1_infl0", io.inflight, 0);

      // contention to full
      reset_pulse();
      set_frame(0, 1);
      set_frame(1, 2);
      io.req0 = 1'b1;
      io.req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_gnt0", io.gnt0, (i % 2 == 0) ? 1 : 0);
         check("t2_gnt1", io.gnt1, i % 2);
         exp_frame.push_back((i % 2 == 0) ? 1 : 2);
         exp_tag.push_back(i % 2);
         cyc();
      end
      check("t2_full", io.inflight, 4);
      #1;
      check("t2_full_gnt0", io.gnt0, 0);
      check("t2_full_gnt1", io.gnt1, 0);

      // full with simultaneous completion
      io.req1 = 1'b0;
      set_frame(0, 3);
      io.fft_output_en = 1'b1;
      #1;
      check("t3_gnt0_blk", io.gnt0, 0);
      cyc();
      io.fft_output_en = 1'b0;
      check("t3_infl3", io.inflight, 3);
      #1;
      check("t3_gnt0", io.gnt0, 1);
      exp_frame.push_back(3);
      exp_tag.push_back(0);
      cyc();
      io.req0 = 1'b0;
      check("t3_infl4", io.inflight, 4);
      io.fft_output_en = 1'b1;
      repeat (4) cyc();
      io.fft_output_en = 1'b0;
      check("t3_drain", io.inflight, 0);

      // pointer wrap, alternating requesters
      for (int c = 0; c < 23; c++) begin
         int i;
         int r;
         io.req0 = 1'b0;
         io.req1 = 1'b0;
         io.fft_output_en = 1'b0;
         i = c / 2;
         r = i % 2;
         if (c % 2 == 0 && c < 20) begin
            set_frame(r, 10 + i);
            if (r == 1) io.req1 = 1'b1;
            else io.req0 = 1'b1;
         end
         if (c >= 3 && (c - 3) % 2 == 0 && (c - 3) / 2 < 10)
            io.fft_output_en = 1'b1;
         #1;
         if (c % 2 == 0 && c < 20) begin
            check("t4_gnt", (r == 1) ? io.gnt1 : io.gnt0, 1);
            exp_frame.push_back(10 + i);
            exp_tag.push_back(r);
         end
         check("t4_max2", (io.inflight <= 2) ? 1 : 0, 1);
         cyc();
      end
      io.req0 = 1'b0;
      io.req1 = 1'b0;
      io.fft_output_en = 1'b0;
      check("t4_infl0", io.inflight, 0);
      check("t4_err0", io.err_spurious, 0);

      // spurious completion, then reset with frames in flight
      io.fft_output_en = 1'b1;
      #1;
      check("t5_done0", io.done0, 0);
      check("t5_done1", io.done1, 0);
      cyc();
      io.fft_output_en = 1'b0;
      check("t5_err", io.err_spurious, 1);
      cyc();
      check("t5_err_held", io.err_spurious, 1);
      set_frame(0, 30);
      io.req0 = 1'b1;
      exp_frame.push_back(30);
      cyc();
      io.req0 = 1'b0;
      set_frame(1, 31);
      io.req1 = 1'b1;
      cyc();
      io.req1 = 1'b0;
      check("t5_infl2", io.inflight, 2);
      rstn = 1'b0;
      #1;
      check("t5_rst_infl", io.inflight, 0);
      check("t5_rst_err", io.err_spurious, 0);
      check("t5_rst_valid", io.fft_valid, 0);
      rstn = 1'b1;
      exp_frame.delete();
      exp_tag.delete();
      io.fft_output_en = 1'b1;
      cyc();
      io.fft_output_en = 1'b0;
      check("t5_err_post", io.err_spurious, 1);

      // enable gating
      io.en = 1'b0;
      set_frame(1, 40);
      io.req1 = 1'b1;
      repeat (5) begin
         #1;
         check("t6_gnt1_off", io.gnt1, 0);
         cyc();
         check("t6_valid_off", io.fft_valid, 0);
      end
      io.en = 1'b1;
      #1;
      check("t6_gnt1_on", io.gnt1, 1);
      exp_frame.push_back(40);
      exp_tag.push_back(1);
      cyc();
      io.req1 = 1'b0;
      io.fft_output_en = 1'b1;
      cyc();
      io.fft_output_en = 1'b0;
      check("t6_infl0", io.inflight, 0);

      cyc();
      cyc();
      check("sb_frames_left", exp_frame.size(), 0);
      check("sb_tags_left", exp_tag.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fft_arb.md
FFT_ARB -- requirements
Module: fft_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum frames in flight inside fft_top (power of 2, 2..16).
REQ-002 SHALL have parameter DW, default 9: input sample width per real/imag lane.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  launch enable; 0 blocks new grants, in-flight frames still complete.
REQ-006 req0  input  1  requester 0 has a 16-point frame on din0_re/din0_im.
REQ-007 din0_re, din0_im  input  16 x DW signed each  requester 0 frame.
REQ-008 req1  input  1  requester 1 has a 16-point frame on din1_re/din1_im.
REQ-009 din1_re, din1_im  input  16 x DW signed each  requester 1 frame.
REQ-010 gnt0, gnt1  output  1 each  combinational accept; transfer occurs on a rising edge where reqX and gntX are both 1.
REQ-011 fft_valid  output  1  registered launch strobe to fft_top valid.
REQ-012 fft_din_re, fft_din_im  output  16 x DW signed each  registered frame to fft_top din_re/din_im.
REQ-013 fft_output_en  input  1  fft_top output_en; one pulse per completed frame, in launch order.
REQ-014 done0, done1  output  1 each  result on fft_top dout belongs to requester 0 / 1.
REQ-015 inflight  output  $clog2(DEPTH+1)  frames launched but not yet completed.
REQ-016 err_spurious  output  1  sticky: fft_output_en seen with no frame in flight.

Function
REQ-017 ready = en and (inflight < DEPTH), evaluated on registered inflight only; a same-cycle completion does not free a slot.
REQ-018 Only req0: gnt0 = ready. Only req1: gnt1 = ready. gnt0 and gnt1 SHALL never both be 1.
REQ-019 Both requesting: grant goes to the requester not granted last; last-grant pointer updates only on a transfer.
REQ-020 No transfer: fft_valid = 0 next cycle, fft_din_* hold previous value.
REQ-021 Transfer on edge N: fft_valid = 1 during cycle N+1, fft_din_* = granted requester's frame sampled at edge N (latency 1 cycle).
REQ-022 Back-to-back transfers permitted every cycle while ready; fft_valid may stay high continuously.
REQ-023 Each transfer pushes the 1-bit requester tag into a DEPTH-entry tag FIFO; inflight increments.
REQ-024 fft_output_en = 1 with inflight > 0: pop head tag; inflight decrements.
REQ-025 done0 = fft_output_en and head tag = 0; done1 = fft_output_en and head tag = 1; combinational, aligned with fft_top dout.
REQ-026 Simultaneous push and pop: inflight unchanged, FIFO pointers both advance, head tag for done taken before the push.
REQ-027 FIFO pointers wrap modulo DEPTH without loss.
REQ-028 fft_output_en with inflight = 0: no pop, done0 = done1 = 0, err_spurious set to 1 and held until reset.
REQ-029 en deasserted: gnt0 = gnt1 = 0 in the same cycle; pops and done continue normally.

Reset
REQ-030 rstn low SHALL asynchronously force: fft_valid = 0, fft_din_* = 0, inflight = 0, FIFO pointers = 0, err_spurious = 0, last-grant pointer = requester 1 (so requester 0 wins the first contention).
REQ-031 While rstn low: gnt0 = gnt1 = 0 and done0 = done1 = 0 regardless of inputs.
REQ-032 Reset mid-operation discards all in-flight tags; output_en pulses after release with inflight = 0 set err_spurious.
REQ-033 First transfer possible on the first rising edge after rstn deasserts.

Verification
REQ-034 Single requester: req0 = 1 for 1 cycle, din0_re[k] = k -> gnt0 = 1 that cycle; next cycle fft_valid = 1, fft_din_re[k] = k; later output_en pulse -> done0 = 1, done1 = 0, inflight 1 -> 0.
REQ-035 Contention: req0 = req1 = 1 held 4 cycles after reset, output_en tied 0, DEPTH = 4 -> grants 0,1,0,1; inflight reaches 4; 5th cycle gnt0 = gnt1 = 0; four output_en pulses -> done0,done1,done0,done1.
REQ-036 Full with simultaneous completion: inflight = 4, output_en = 1 and req0 = 1 same cycle -> gnt0 = 0 that cycle, inflight = 3; next cycle gnt0 = 1, inflight stays 4 after that edge if output_en = 0.
REQ-037 Wrap: 10 alternating single-requester frames, each completed 3 cycles after launch -> done sequence matches grant sequence exactly, inflight never exceeds 2, err_spurious = 0.
REQ-038 Spurious and reset: output_en = 1 with inflight = 0 -> done0 = done1 = 0, err_spurious = 1 and held; rstn pulse low with inflight = 2 -> inflight = 0, err_spurious = 0, fft_valid = 0 immediately.
REQ-039 Enable gating: en = 0, req1 = 1 for 5 cycles -> gnt1 = 0, fft_valid = 0 throughout; en = 1 -> gnt1 = 1 same cycle.
